gamepad_scanner: RTL and testbench

GAMEPAD_SCANNER -- requirements
Module: gamepad_scanner

---
 rtl/gametank_pkg.sv | 21 ++
 rtl/gamepad_regs.sv | 61 ++++++
 rtl/gamepad_scanner.sv | 157 +++++++++++++++
 tb/tb_gamepad_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gametank_pkg.sv
// Shared definitions for the GameTank gamepad scanner: FSM states,
// register window offsets and the default bus address of the window.
package gametank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_COMMIT = 3'd5
    } scan_state_t;

    localparam logic [1:0]  OFF_PAD1_LO = 2'd0;
    localparam logic [1:0]  OFF_PAD1_HI = 2'd1;
    localparam logic [1:0]  OFF_PAD2_LO = 2'd2;
    localparam logic [1:0]  OFF_PAD2_HI = 2'd3;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h2008;

endpackage

// File: rtl/gamepad_regs.sv
// CPU read window over the held pad registers, with lo-byte-read shadowing
// so a lo/hi read pair stays coherent across a scan commit.
module gamepad_regs
    import gametank_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        i_ce,
    input  logic        i_rnw,
    input  logic [15:0] i_addr,
    input  logic [15:0] pad1,
    input  logic [15:0] pad2,
    output logic [7:0]  o_data_out,
    output logic        o_sel
);

    logic [15:0] offset;
    logic        rd;
    logic [7:0]  shadow1;
    logic [7:0]  shadow2;
    logic        shadow1_valid;
    logic        shadow2_valid;

    assign offset = i_addr - BASE_ADDR;
    assign rd     = i_ce & i_rnw & (offset[15:2] == 14'd0);

    // Registered read mux; lo-byte reads snapshot the matching high byte.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data_out    <= 8'hFF;
            o_sel         <= 1'b0;
            shadow1       <= 8'h00;
            shadow2       <= 8'h00;
            shadow1_valid <= 1'b0;
            shadow2_valid <= 1'b0;
        end else if (rd) begin
            o_sel <= 1'b1;
            case (offset[1:0])
                OFF_PAD1_LO: begin
                    o_data_out    <= pad1[7:0];
                    shadow1       <= pad1[15:8];
                    shadow1_valid <= 1'b1;
                end
                OFF_PAD1_HI: o_data_out <= shadow1_valid ? shadow1 : pad1[15:8];
                OFF_PAD2_LO: begin
                    o_data_out    <= pad2[7:0];
                    shadow2       <= pad2[15:8];
                    shadow2_valid <= 1'b1;
                end
                OFF_PAD2_HI: o_data_out <= shadow2_valid ? shadow2 : pad2[15:8];
                default:     o_data_out <= 8'hFF;
            endcase
        end else begin
            o_data_out <= 8'hFF;
            o_sel      <= 1'b0;
        end
    end

endmodule

// File: rtl/gamepad_scanner.sv
// Serial gamepad scanner: strobes both pads, clocks out 16 bits from each,
// and commits them to held registers exposed through gamepad_regs.
module gamepad_scanner
    import gametank_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        i_scan_req,
    input  logic        i_ce,
    input  logic        i_rnw,
    input  logic [15:0] i_addr,
    output logic [7:0]  o_data_out,
    output logic        o_sel,
    output logic        joy1_strb,
    output logic        joy2_strb,
    output logic        joy1_clk,
    output logic        joy2_clk,
    input  logic        joy1_data,
    input  logic        joy2_data,
    output logic        o_busy,
    output logic        o_scan_done
);

    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] PHASE_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shift1;
    logic [15:0]   shift2;
    logic [15:0]   pad1;
    logic [15:0]   pad2;
    logic          strb;
    logic          pclk;

    assign joy1_strb = strb;
    assign joy2_strb = strb;
    assign joy1_clk  = pclk;
    assign joy2_clk  = pclk;

    // Scan sequencer; every phase is timed by the one down-counter and
    // the pad pins are registered alongside the state transitions.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_cnt     <= 4'd0;
            shift1      <= 16'h0000;
            shift2      <= 16'h0000;
            pad1        <= 16'h0000;
            pad2        <= 16'h0000;
            strb        <= 1'b0;
            pclk        <= 1'b1;
            o_busy      <= 1'b0;
            o_scan_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    strb        <= 1'b0;
                    pclk        <= 1'b1;
                    o_scan_done <= 1'b0;
                    if (i_scan_req) begin
                        state  <= ST_STROBE;
                        cnt    <= STROBE_LOAD;
                        strb   <= 1'b1;
                        o_busy <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= PHASE_LOAD;
                        strb  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CLK_LO;
                        cnt   <= PHASE_LOAD;
                        pclk  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_CLK_LO: begin
                    // First low cycle is the sample point; pad data is active-low.
                    if (cnt == PHASE_LOAD) begin
                        shift1[bit_cnt] <= ~joy1_data;
                        shift2[bit_cnt] <= ~joy2_data;
                    end else begin
                        shift1 <= shift1;
                    end
                    if (cnt == '0) begin
                        state <= ST_CLK_HI;
                        cnt   <= PHASE_LOAD;
                        pclk  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_CLK_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (bit_cnt == 4'd15) begin
                        state       <= ST_COMMIT;
                        o_scan_done <= 1'b1;
                    end else begin
                        state   <= ST_CLK_LO;
                        cnt     <= PHASE_LOAD;
                        bit_cnt <= bit_cnt + 4'd1;
                        pclk    <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    pad1        <= shift1;
                    pad2        <= shift2;
                    bit_cnt     <= bit_cnt + 4'd1;
                    o_scan_done <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    strb        <= 1'b0;
                    pclk        <= 1'b1;
                    o_busy      <= 1'b0;
                    o_scan_done <= 1'b0;
                end
            endcase
        end
    end

    gamepad_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .i_ce       (i_ce),
        .i_rnw      (i_rnw),
        .i_addr     (i_addr),
        .pad1       (pad1),
        .pad2       (pad2),
        .o_data_out (o_data_out),
        .o_sel      (o_sel)
    );

endmodule

// File: tb/tb_gamepad_scanner.sv
// Self-checking bench for gamepad_scanner with CLK_DIV=4, behavioural pad
// models and a read-window reference model.
module tb_gamepad_scanner;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_scan_req = 1'b0;
    logic        i_ce = 1'b0;
    logic        i_rnw = 1'b1;
    logic [15:0] i_addr = 16'h0000;
    logic [7:0]  o_data_out;
    logic        o_sel;
    logic        joy1_strb, joy2_strb, joy1_clk, joy2_clk;
    logic        joy1_data, joy2_data;
    logic        o_busy, o_scan_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Pad models: raw wire levels, bit 0 presented first after strobe.
    logic [15:0] raw1 = 16'hFFFF, raw2 = 16'hFFFF;
    int          idx1 = 16, idx2 = 16;
    logic        prev1 = 1'b1, prev2 = 1'b1;

    // Read-window reference model.
    logic [15:0] held_m [2];
    logic [7:0]  sh_m   [2];
    bit          sv_m   [2];

    gamepad_scanner #(.CLK_DIV(4), .BASE_ADDR(16'h2008)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .i_scan_req(i_scan_req),
        .i_ce(i_ce), .i_rnw(i_rnw), .i_addr(i_addr),
        .o_data_out(o_data_out), .o_sel(o_sel),
        .joy1_strb(joy1_strb), .joy2_strb(joy2_strb),
        .joy1_clk(joy1_clk), .joy2_clk(joy2_clk),
        .joy1_data(joy1_data), .joy2_data(joy2_data),
        .o_busy(o_busy), .o_scan_done(o_scan_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        prev1 <= joy1_clk;
        prev2 <= joy2_clk;
        if (joy1_strb) idx1 <= 0;
        else if (joy1_clk && !prev1 && idx1 < 16) idx1 <= idx1 + 1;
        if (joy2_strb) idx2 <= 0;
        else if (joy2_clk && !prev2 && idx2 < 16) idx2 <= idx2 + 1;
    end

    assign joy1_data = (idx1 < 16) ? raw1[idx1[3:0]] : 1'b1;
    assign joy2_data = (idx2 < 16) ? raw2[idx2[3:0]] : 1'b1;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            held_m[p] = 16'h0000; sh_m[p] = 8'h00; sv_m[p] = 1'b0;
        end
    endtask

    task automatic model_read(input int off, output logic [7:0] v);
        int p = off / 2;
        if (off % 2 == 0) begin
            v = held_m[p][7:0];
            sh_m[p] = held_m[p][15:8];
            sv_m[p] = 1'b1;
        end else begin
            v = sv_m[p] ? sh_m[p] : held_m[p][15:8];
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic rnw,
                            output logic [7:0] d, output logic s);
        @(negedge sys_clk);
        i_ce = 1'b1; i_rnw = rnw; i_addr = a;
        @(posedge sys_clk); #1;
        d = o_data_out; s = o_sel;
        i_ce = 1'b0; i_rnw = 1'b1;
    endtask

    task automatic run_scan();
        bit seen = 1'b0;
        @(negedge sys_clk); i_scan_req = 1'b1;
        @(negedge sys_clk); i_scan_req = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (o_scan_done) seen = 1'b1;
            @(negedge sys_clk);
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_timeout: got done=%0b want 1", seen);
        end
        held_m[0] = ~raw1;
        held_m[1] = ~raw2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({o_data_out, o_sel, joy1_clk, joy2_clk, joy1_strb, joy2_strb, o_busy, o_scan_done}
            !== {8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h sel=%b clk=%b strb=%b busy=%b done=%b",
                     o_data_out, o_sel, joy1_clk, joy1_strb, o_busy, o_scan_done);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan_timing();
        int strb_cyc = 0, pulses = 0, run = 0, bad_w = 0, bad_p = 0;
        int last_fall = -1, first_fall = -1, done_cnt = 0, after = 0;
        logic pc = 1'b1;
        logic busy_after = 1'b1;
        raw1 = 16'($urandom); raw2 = 16'($urandom);
        @(negedge sys_clk); i_scan_req = 1'b1;
        @(negedge sys_clk); i_scan_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (after == 1) begin busy_after = o_busy; break; end
            strb_cyc += int'(joy1_strb);
            if (!joy1_clk && pc) begin
                if (first_fall < 0) first_fall = c;
                if (last_fall >= 0 && c - last_fall != 8) bad_p++;
                last_fall = c;
            end
            if (!joy1_clk) run++;
            else if (run > 0) begin pulses++; if (run != 4) bad_w++; run = 0; end
            pc = joy1_clk;
            if (o_scan_done) begin done_cnt++; after = 1; end
            @(negedge sys_clk);
        end
        held_m[0] = ~raw1; held_m[1] = ~raw2;
        n_checks++; if (strb_cyc !== 8) begin n_fail++; $display("FAIL strobe_len: got %0d want 8", strb_cyc); end
        n_checks++; if (first_fall !== 12) begin n_fail++; $display("FAIL first_clk_low: got %0d want 12", first_fall); end
        n_checks++; if (pulses !== 16) begin n_fail++; $display("FAIL clk_pulses: got %0d want 16", pulses); end
        n_checks++; if (bad_w !== 0) begin n_fail++; $display("FAIL clk_low_width: got %0d bad want 0", bad_w); end
        n_checks++; if (bad_p !== 0) begin n_fail++; $display("FAIL clk_period: got %0d bad want 0", bad_p); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", done_cnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy_after); end
    endtask

    task automatic test_decode();
        logic [7:0] d, e; logic s;
        logic [7:0] fixed [4];
        fixed[0] = 8'h0F; fixed[1] = 8'hFF; fixed[2] = 8'h01; fixed[3] = 8'h00;
        raw1 = 16'h00F0; raw2 = 16'hFFFE;
        run_scan();
        for (int o = 0; o < 4; o++) begin
            bus_read(16'h2008 + 16'(o), 1'b1, d, s);
            model_read(o, e);
            n_checks++;
            if (d !== fixed[o] || s !== 1'b1) begin
                n_fail++;
                $display("FAIL decode_fixed off%0d: got %h sel=%b want %h sel=1", o, d, s, fixed[o]);
            end
        end
        for (int it = 0; it < 4; it++) begin
            raw1 = 16'($urandom); raw2 = 16'($urandom);
            run_scan();
            for (int o = 0; o < 4; o++) begin
                bus_read(16'h2008 + 16'(o), 1'b1, d, s);
                model_read(o, e);
                n_checks++;
                if (d !== e || s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL decode_rand it%0d off%0d: got %h sel=%b want %h", it, o, d, s, e);
                end
            end
        end
    endtask

    task automatic test_coherent();
        logic [7:0] d, e; logic s;
        raw1 = 16'($urandom) | 16'h0100;
        run_scan();
        bus_read(16'h2008, 1'b1, d, s); model_read(0, e);
        raw1 = ~16'h1234;
        run_scan();
        bus_read(16'h2009, 1'b1, d, s); model_read(1, e);
        n_checks++;
        if (d !== e || d === 8'h12) begin
            n_fail++; $display("FAIL coherent_old_hi: got %h want %h", d, e);
        end
        bus_read(16'h2008, 1'b1, d, s); model_read(0, e);
        n_checks++; if (d !== 8'h34) begin n_fail++; $display("FAIL coherent_new_lo: got %h want 34", d); end
        bus_read(16'h2009, 1'b1, d, s); model_read(1, e);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL coherent_new_hi: got %h want 12", d); end
    endtask

    task automatic test_busy_req();
        int rises = 0, dones = 0;
        logic ps = 1'b0;
        raw1 = 16'($urandom); raw2 = 16'($urandom);
        @(negedge sys_clk); i_scan_req = 1'b1;
        @(negedge sys_clk); i_scan_req = 1'b0;
        ps = 1'b0;
        for (int c = 0; c < 250; c++) begin
            if (joy1_strb && !ps) rises++;
            ps = joy1_strb;
            dones += int'(o_scan_done);
            i_scan_req = (c == 20);
            @(negedge sys_clk);
        end
        i_scan_req = 1'b0;
        held_m[0] = ~raw1; held_m[1] = ~raw2;
        n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL busy_req_strobes: got %0d want 1", rises); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_req_dones: got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid();
        int falls = 0;
        logic pc = 1'b1;
        logic [7:0] d, e; logic s;
        raw1 = 16'h0000; raw2 = 16'h0000;
        @(negedge sys_clk); i_scan_req = 1'b1;
        @(negedge sys_clk); i_scan_req = 1'b0;
        for (int c = 0; c < 300 && falls < 8; c++) begin
            if (!joy1_clk && pc) falls++;
            pc = joy1_clk;
            if (falls < 8) @(negedge sys_clk);
        end
        n_checks++; if (falls !== 8) begin n_fail++; $display("FAIL reset_mid_reach_bit7: got %0d want 8", falls); end
        reset_n = 1'b0; #1;
        n_checks++;
        if ({joy1_clk, joy2_clk, joy1_strb, joy2_strb, o_busy} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got clk=%b strb=%b busy=%b want clk=1 strb=0 busy=0",
                     joy1_clk, joy1_strb, o_busy);
        end
        model_reset();
        @(negedge sys_clk); reset_n = 1'b1;
        repeat (150) @(negedge sys_clk);
        foreach (held_m[p]) held_m[p] = held_m[p];
        for (int k = 0; k < 4; k++) begin
            int o = (k + 1) % 4;
            bus_read(16'h2008 + 16'(o), 1'b1, d, s);
            model_read(o, e);
            n_checks++;
            if (d !== 8'h00 || d !== e) begin
                n_fail++; $display("FAIL reset_mid_held off%0d: got %h want 00", o, d);
            end
        end
    endtask

    task automatic test_unselected();
        logic [7:0] d; logic s;
        logic [15:0] addrs [4];
        addrs[0] = 16'h8000; addrs[1] = 16'h200C; addrs[2] = 16'h2007; addrs[3] = 16'($urandom_range(16'h3000, 16'hFFFF));
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], 1'b1, d, s);
            n_checks++;
            if (d !== 8'hFF || s !== 1'b0) begin
                n_fail++; $display("FAIL unselected %h: got %h sel=%b want FF sel=0", addrs[i], d, s);
            end
        end
        bus_read(16'h2008, 1'b0, d, s);
        n_checks++;
        if (d !== 8'hFF || s !== 1'b0) begin
            n_fail++; $display("FAIL write_ignored: got %h sel=%b want FF sel=0", d, s);
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_decode();
        test_coherent();
        test_busy_req();
        test_unselected();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
